// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the 7-segment display arbiter.
package seg_disp_pkg;

   // Display geometry: four hex digits of four bits each.
   localparam int DIGIT_W     = 4;
   localparam int DISP_DIGITS = 4;

   // System clock rate and the default one-second hold window.
   localparam int CLK_HZ  = 20_000_000;
   localparam int HOLD_1S = CLK_HZ;

   // Arbiter FSM: IDLE waits for a request, SHOW runs a hold window.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SHOW = 1'b1
   } disp_arb_state_t;

   // Circular increment used to advance the round-robin pointer.
   function automatic int wrap_inc(input int val, input int modulus);
      return (val + 1) % modulus;
   endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// Combinational circular priority picker: the first asserted request at or
// after ptr wins, wrapping around past N-1 back to 0.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   // Scan N positions starting at ptr and keep the first hit.
   always_comb begin
      int cand;
      cand  = 0;
      grant = '0;
      index = '0;
      any   = 1'b0;
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr) + off) % N;
         if (!any && req[cand[IDX_W-1:0]]) begin
            any                      = 1'b1;
            index                    = cand[IDX_W-1:0];
            grant[cand[IDX_W-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Shares one 4-digit hex display between NUM_REQ sources. Round-robin
// arbitration grants one source at a time; the winning word is latched and
// held for HOLD_CYCLES clocks. A debug force mode shows one source live and
// freezes arbitration while active.
module seg_disp_arbiter
   import seg_disp_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = DIGIT_W * DISP_DIGITS,
   parameter int HOLD_CYCLES = HOLD_1S,
   localparam int IDX_W      = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      force_en,
   input  logic [IDX_W-1:0]          force_sel,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         disp_data,
   output logic [IDX_W-1:0]          disp_src,
   output logic                      disp_busy
);

   // Final count value of a hold window.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

   disp_arb_state_t      state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0]    disp_data_q, disp_data_d;
   logic [IDX_W-1:0]     disp_src_q, disp_src_d;
   logic                 disp_busy_q, disp_busy_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;

   logic [DATA_W-1:0]    words [NUM_REQ];
   logic [NUM_REQ-1:0]   pick_grant;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [IDX_W-1:0]     force_idx;
   logic                 window_open;
   logic                 do_grant;

   // Unpack the flat source bus into one word per requester.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
         assign words[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .index (pick_idx),
      .any   (pick_any)
   );

   // Out-of-range debug selects fall back to source 0.
   assign force_idx = (int'(force_sel) >= NUM_REQ) ? '0 : force_sel;

   // A grant may land when idle, or on the last cycle of a running window so
   // back-to-back grants leave no gap on the display.
   assign window_open = (state_q == IDLE) || (hold_cnt_q == LAST_CNT);
   assign do_grant    = !force_en && pick_any && window_open;

   // Next-state logic for the FSM, counter, pointer and output registers.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      hold_cnt_d  = hold_cnt_q;
      disp_data_d = disp_data_q;
      disp_src_d  = disp_src_q;
      disp_busy_d = disp_busy_q;
      ack_d       = '0;

      if (force_en) begin
         // Live debug view; everything else stays frozen.
         disp_data_d = words[force_idx];
         disp_src_d  = force_idx;
      end else if (do_grant) begin
         disp_data_d = words[pick_idx];
         disp_src_d  = pick_idx;
         ack_d       = pick_grant;
         rr_ptr_d    = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
         hold_cnt_d  = '0;
         disp_busy_d = 1'b1;
         state_d     = SHOW;
      end else if (state_q == SHOW) begin
         if (hold_cnt_q == LAST_CNT) begin
            // Window over with nobody waiting: keep the word, drop busy.
            state_d     = IDLE;
            disp_busy_d = 1'b0;
            hold_cnt_d  = '0;
         end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
         end
      end
   end

   // State and output registers; reset aborts any window without an ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         hold_cnt_q  <= '0;
         disp_data_q <= '0;
         disp_src_q  <= '0;
         disp_busy_q <= 1'b0;
         ack_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         disp_data_q <= disp_data_d;
         disp_src_q  <= disp_src_d;
         disp_busy_q <= disp_busy_d;
         ack_q       <= ack_d;
      end
   end

   assign ack       = ack_q;
   assign disp_data = disp_data_q;
   assign disp_src  = disp_src_q;
   assign disp_busy = disp_busy_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter with NUM_REQ=4, HOLD_CYCLES=8.
module tb_seg_disp_arbiter;

   localparam int NR   = 4;
   localparam int DW   = 16;
   localparam int HOLD = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_data;
   logic          force_en;
   logic [1:0]    force_sel;
   logic [NR-1:0] ack;
   logic [DW-1:0] disp_data;
   logic [1:0]    disp_src;
   logic          disp_busy;

   int n_tests = 0;
   int n_fail  = 0;

   seg_disp_arbiter #(
      .NUM_REQ     (NR),
      .DATA_W      (DW),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .force_en  (force_en),
      .force_sel (force_sel),
      .ack       (ack),
      .disp_data (disp_data),
      .disp_src  (disp_src),
      .disp_busy (disp_busy)
   );

   always #5 clk = ~clk;

   // Directed vector: apply req for 'cycles' edges; ack must stay 0 until the
   // last edge, after which all outputs must match.
   typedef struct {
      logic [3:0]  req;
      int          cycles;
      logic [3:0]  ack;
      logic [1:0]  src;
      logic        busy;
      logic [15:0] data;
   } vec_t;

   vec_t vecs [16];

   // Behavioural reference: who is shown, how long the window has run, and
   // whose turn is first.
   int          m_ptr;
   int          m_elapsed;
   bit          m_busy;
   logic [3:0]  m_ack;
   logic [15:0] m_data;
   logic [1:0]  m_src;

   function automatic logic [22:0] outs();
      return {ack, disp_src, disp_busy, disp_data};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_elapsed = 0; m_busy = 0;
      m_ack = '0; m_data = '0; m_src = '0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic fe, input logic [1:0] fs,
                             input logic [63:0] d);
      int  w;
      bit  can_show;
      m_ack = '0;
      if (fe) begin
         m_data = d[fs*16 +: 16];
         m_src  = fs;
      end else begin
         can_show = !m_busy || (m_elapsed == HOLD - 1);
         if (can_show && r != 4'b0) begin
            w = -1;
            for (int k = 0; k < NR; k++)
               if (w < 0 && r[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            m_ack[w]  = 1'b1;
            m_data    = d[w*16 +: 16];
            m_src     = 2'(w);
            m_ptr     = (w + 1) % NR;
            m_busy    = 1;
            m_elapsed = 0;
         end else if (m_busy) begin
            if (m_elapsed == HOLD - 1) m_busy = 0;
            else m_elapsed++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] fv;
      logic [15:0] last_fv;
      logic [3:0]  pend;
      int          force_left;

      vecs[0]  = '{4'hF, 1, 4'h1, 2'd0, 1'b1, 16'hA000};
      vecs[1]  = '{4'hF, 7, 4'h0, 2'd0, 1'b1, 16'hA000};
      vecs[2]  = '{4'hF, 1, 4'h2, 2'd1, 1'b1, 16'hA111};
      vecs[3]  = '{4'hF, 7, 4'h0, 2'd1, 1'b1, 16'hA111};
      vecs[4]  = '{4'hF, 1, 4'h4, 2'd2, 1'b1, 16'hBEEF};
      vecs[5]  = '{4'hF, 7, 4'h0, 2'd2, 1'b1, 16'hBEEF};
      vecs[6]  = '{4'hF, 1, 4'h8, 2'd3, 1'b1, 16'hA333};
      vecs[7]  = '{4'h0, 7, 4'h0, 2'd3, 1'b1, 16'hA333};
      vecs[8]  = '{4'h0, 1, 4'h0, 2'd3, 1'b0, 16'hA333};
      vecs[9]  = '{4'h4, 1, 4'h4, 2'd2, 1'b1, 16'hBEEF};
      vecs[10] = '{4'h0, 7, 4'h0, 2'd2, 1'b1, 16'hBEEF};
      vecs[11] = '{4'h0, 1, 4'h0, 2'd2, 1'b0, 16'hBEEF};
      vecs[12] = '{4'h1, 1, 4'h1, 2'd0, 1'b1, 16'hA000};
      vecs[13] = '{4'h0, 3, 4'h0, 2'd0, 1'b1, 16'hA000};
      vecs[14] = '{4'h2, 4, 4'h0, 2'd0, 1'b1, 16'hA000};
      vecs[15] = '{4'h2, 1, 4'h2, 2'd1, 1'b1, 16'hA111};

      // Reset with every source requesting.
      rst_n     = 1'b0;
      req       = 4'hF;
      req_data  = {16'hA333, 16'hBEEF, 16'hA111, 16'hA000};
      force_en  = 1'b0;
      force_sel = 2'd0;
      repeat (3) tick();
      check("reset_outs", 64'(outs()), 64'(0));
      rst_n = 1'b1;

      // Table: four back-to-back windows, idle pulse, mid-hold request.
      for (int i = 0; i < 16; i++) begin
         req = vecs[i].req;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            tick();
            if (c < vecs[i].cycles - 1)
               check($sformatf("vec%0d_ack_gap", i), 64'(ack), 64'(0));
         end
         check($sformatf("vec%0d", i), 64'(outs()),
               64'({vecs[i].ack, vecs[i].src, vecs[i].busy, vecs[i].data}));
         $display("[TB] vec %0d req=%b cycles=%0d ack=%b src=%0d busy=%b data=%h",
                  i, vecs[i].req, vecs[i].cycles, ack, disp_src, disp_busy, disp_data);
      end

      // Force mid-window: source 1 window at count 2, source 0 pending.
      req = 4'h0;
      repeat (2) tick();
      req       = 4'h1;
      force_en  = 1'b1;
      force_sel = 2'd3;
      last_fv   = '0;
      for (int i = 0; i < 4; i++) begin
         fv = 16'($urandom);
         req_data[3*16 +: 16] = fv;
         tick();
         check($sformatf("force%0d", i), 64'(outs()), 64'({4'h0, 2'd3, 1'b1, fv}));
         last_fv = fv;
      end
      force_en = 1'b0;
      req_data[3*16 +: 16] = 16'hA333;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("after_force%0d", i), 64'(outs()), 64'({4'h0, 2'd3, 1'b1, last_fv}));
      end
      tick();
      check("after_force_grant", 64'(outs()), 64'({4'h1, 2'd0, 1'b1, 16'hA000}));
      $display("[TB] force sequence done ack=%b src=%0d data=%h", ack, disp_src, disp_data);

      // Reset pulsed at count 5 of source 0's window (pointer now 1).
      req = 4'h0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'(outs()), 64'(0));
      tick();
      check("reset_held", 64'(outs()), 64'(0));
      req   = 4'h9;
      rst_n = 1'b1;
      tick();
      check("restart_ptr0", 64'(outs()), 64'({4'h1, 2'd0, 1'b1, 16'hA000}));
      $display("[TB] reset restart ack=%b src=%0d", ack, disp_src);

      // Randomized traffic against the reference model.
      rst_n = 1'b0;
      req   = 4'h0;
      repeat (2) tick();
      rst_n = 1'b1;
      model_reset();
      pend       = '0;
      force_left = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int s = 0; s < NR; s++) begin
            if (m_ack[s]) pend[s] = 1'b0;
            else if (!pend[s] && $urandom_range(0, 9) == 0) pend[s] = 1'b1;
            else if (pend[s] && $urandom_range(0, 49) == 0) pend[s] = 1'b0;
         end
         req = pend;
         if (force_left > 0) begin
            force_en = 1'b1;
            force_left--;
         end else if ($urandom_range(0, 59) == 0) begin
            force_en   = 1'b1;
            force_left = $urandom_range(0, 11);
         end else begin
            force_en = 1'b0;
         end
         force_sel = 2'($urandom_range(0, 3));
         req_data  = {$urandom, $urandom};
         @(posedge clk);
         model_edge(req, force_en, force_sel, req_data);
         #1;
         check($sformatf("rand%0d", cyc), 64'(outs()),
               64'({m_ack, m_src, 1'(m_busy), m_data}));
      end
      $display("[TB] random phase done, 2000 cycles");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
